muldiv_hilo: RTL

MULDIV_HILO -- requirements
Module: muldiv_hilo

---
 rtl/muldiv_hilo.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_hilo.sv
// Iterative 32x32 multiply / divide unit with HI/LO result registers and mthi/mtlo moves.
// Define MULDIV_FAST_MUL_EN to make MULT/MULTU single-cycle; divides stay 32-cycle iterative.
module muldiv_hilo (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_content,
  input  logic [31:0] rt_content,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] m_q, m_d;
  logic [31:0] rs_q, rs_d;
  logic [63:0] work_q, work_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] add_sum, sub_shift, sub_diff;
  logic        sub_ge;
  logic [63:0] step, prod;
  logic [31:0] quo, rem;
`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_a, fast_b, fast_prod;
`endif

  always_comb begin
    a_neg = ~op[0] & rs_content[31];
    b_neg = ~op[0] & rt_content[31];
    a_mag = a_neg ? -rs_content : rs_content;
    b_mag = b_neg ? -rt_content : rt_content;

    // work_q packs {upper accumulator / remainder, multiplier / dividend bits}
    add_sum   = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, m_q} : 33'd0);
    sub_shift = work_q[63:31];
    sub_ge    = sub_shift >= {1'b0, m_q};
    sub_diff  = sub_shift - {1'b0, m_q};
    if (is_div_q) begin
      step = sub_ge ? {sub_diff[31:0], work_q[30:0], 1'b1}
                    : {sub_shift[31:0], work_q[30:0], 1'b0};
    end else begin
      step = {add_sum, work_q[31:1]};
    end
    prod = neg_quo_q ? -step : step;
    quo  = neg_quo_q ? -step[31:0] : step[31:0];
    rem  = neg_rem_q ? -step[63:32] : step[63:32];

    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    m_d       = m_q;
    rs_d      = rs_q;
    work_d    = work_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
    fast_a    = {{32{a_neg}}, rs_content};
    fast_b    = {{32{b_neg}}, rt_content};
    fast_prod = fast_a * fast_b;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef MULDIV_FAST_MUL_EN
          if (!op[1]) begin
            hi_d   = fast_prod[63:32];
            lo_d   = fast_prod[31:0];
            done_d = 1'b1;
          end else begin
`else
          begin
`endif
            state_d   = RUN;
            cnt_d     = '0;
            is_div_d  = op[1];
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            rs_d      = rs_content;
            m_d       = op[1] ? b_mag : a_mag;
            work_d    = {32'd0, op[1] ? a_mag : b_mag};
          end
        end else begin
          if (mthi) hi_d = rs_content;
          if (mtlo) lo_d = rs_content;
        end
      end
      RUN: begin
        work_d = step;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (is_div_q) begin
            if (m_q == '0) begin
              hi_d = rs_q;
              lo_d = '1;
            end else begin
              hi_d = rem;
              lo_d = quo;
            end
          end else begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      m_q       <= '0;
      rs_q      <= '0;
      work_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      m_q       <= m_d;
      rs_q      <= rs_d;
      work_q    <= work_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
